// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, instruction-memory addressing,
// fetch address-error detection and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_in_d,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] im_instr,
  output logic [11:0] im_addr,
  output logic        im_exc,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [4:0]  exccode_d,
  output logic        bd_d
);

  localparam logic [31:0] PC_LAST    = PC_RESET + 32'(IM_WORDS * 4) - 32'd4;
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pc_off_s;
  logic        fetch_err_s;

  logic [31:0] instr_r,   instr_next_s;
  logic [31:0] pcd_r,     pcd_next_s;
  logic [4:0]  exccode_r, exccode_next_s;
  logic        bd_r,      bd_next_s;

  // Address translation and fetch range / alignment check.
  always_comb begin
    pc_off_s    = pc_r - PC_RESET;
    fetch_err_s = (pc_r[1:0] != 2'b00) || (pc_r < PC_RESET) || (pc_r > PC_LAST);
  end

  assign im_addr = pc_off_s[13:2];
  assign im_exc  = fetch_err_s;

  // Next-PC selection; exception entry and eret override a hazard stall.
  always_comb begin
    pc_next_s = pc_r + 32'd4;
    if (exc_req) begin
      pc_next_s = HANDLER_PC;
    end else if (eret) begin
      pc_next_s = epc;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else if (br_taken) begin
      pc_next_s = br_target;
    end else begin
      pc_next_s = pc_r + 32'd4;
    end
  end

  // IF/ID next value: flush on exception/eret, hold on stall, else load fetch.
  always_comb begin
    instr_next_s   = instr_r;
    pcd_next_s     = pcd_r;
    exccode_next_s = exccode_r;
    bd_next_s      = bd_r;
    if (exc_req || eret) begin
      // Bubble carries the redirect PC so CP0 always sees a valid PC in ID.
      instr_next_s   = 32'd0;
      pcd_next_s     = exc_req ? HANDLER_PC : epc;
      exccode_next_s = EXC_NONE;
      bd_next_s      = 1'b0;
    end else if (stall) begin
      instr_next_s   = instr_r;
      pcd_next_s     = pcd_r;
      exccode_next_s = exccode_r;
      bd_next_s      = bd_r;
    end else begin
      instr_next_s   = fetch_err_s ? 32'd0 : im_instr;
      pcd_next_s     = pc_r;
      exccode_next_s = fetch_err_s ? EXC_ADEL : EXC_NONE;
      bd_next_s      = br_in_d;
    end
  end

  // PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= PC_RESET;
      instr_r   <= 32'd0;
      pcd_r     <= 32'd0;
      exccode_r <= 5'd0;
      bd_r      <= 1'b0;
    end else begin
      pc_r      <= pc_next_s;
      instr_r   <= instr_next_s;
      pcd_r     <= pcd_next_s;
      exccode_r <= exccode_next_s;
      bd_r      <= bd_next_s;
    end
  end

  assign pc_f      = pc_r;
  assign instr_d   = instr_r;
  assign pc_d      = pcd_r;
  assign exccode_d = exccode_r;
  assign bd_d      = bd_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; instruction memory returns
// 0xC0DE0000 | word address so every fetched word is identifiable.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, br_in_d, exc_req, eret;
  logic [31:0] br_target, epc, im_instr;
  logic [11:0] im_addr;
  logic        im_exc;
  logic [31:0] pc_f, instr_d, pc_d;
  logic [4:0]  exccode_d;
  logic        bd_d;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .br_in_d(br_in_d), .exc_req(exc_req),
    .eret(eret), .epc(epc), .im_instr(im_instr), .im_addr(im_addr),
    .im_exc(im_exc), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
    .exccode_d(exccode_d), .bd_d(bd_d)
  );

  always #5 clk = ~clk;

  assign im_instr = 32'hC0DE_0000 | {20'd0, im_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pcd,
                          input logic [4:0] exc, input logic bd);
    chk({tag, ".instr_d"}, instr_d, ins);
    chk({tag, ".pc_d"}, pc_d, pcd);
    chk({tag, ".exccode_d"}, 32'(exccode_d), 32'(exc));
    chk({tag, ".bd_d"}, 32'(bd_d), 32'(bd));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_in_d = 1'b0;
    exc_req = 1'b0; eret = 1'b0; br_target = 32'd0; epc = 32'd0;
    step(); step();
    chk("rst.pc_f", pc_f, 32'h3000);
    chk("rst.im_addr", 32'(im_addr), 32'd0);
    chk("rst.im_exc", 32'(im_exc), 32'd0);
    chk_ifid("rst", 32'd0, 32'd0, 5'd0, 1'b0);

    // Sequential fetch
    reset = 1'b0;
    step();
    chk("seq1.pc_f", pc_f, 32'h3004);
    chk("seq1.im_addr", 32'(im_addr), 32'd1);
    chk_ifid("seq1", 32'hC0DE_0000, 32'h3000, 5'd0, 1'b0);
    step();
    chk("seq2.pc_f", pc_f, 32'h3008);
    chk("seq2.im_addr", 32'(im_addr), 32'd2);
    chk_ifid("seq2", 32'hC0DE_0001, 32'h3004, 5'd0, 1'b0);

    // Branch with delay slot
    br_taken = 1'b1; br_in_d = 1'b1; br_target = 32'h3100;
    step();
    chk("br.pc_f", pc_f, 32'h3100);
    chk("br.im_addr", 32'(im_addr), 32'h40);
    chk_ifid("br", 32'hC0DE_0002, 32'h3008, 5'd0, 1'b1);

    // Redirect to 0x3010 to set up the stall test
    br_in_d = 1'b0; br_target = 32'h3010;
    step();
    chk("br2.pc_f", pc_f, 32'h3010);
    chk_ifid("br2", 32'hC0DE_0040, 32'h3100, 5'd0, 1'b0);

    // Stall for 3 cycles; a branch during stall is ignored
    br_taken = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      br_taken  = (i == 1);
      br_target = 32'h3500;
      step();
      chk("stall.pc_f", pc_f, 32'h3010);
      chk_ifid("stall", 32'hC0DE_0040, 32'h3100, 5'd0, 1'b0);
    end
    br_taken = 1'b0; stall = 1'b0;
    step();
    chk("unstall.pc_f", pc_f, 32'h3014);
    chk_ifid("unstall", 32'hC0DE_0004, 32'h3010, 5'd0, 1'b0);

    // Exception overriding stall
    exc_req = 1'b1; stall = 1'b1;
    step();
    chk("exc.pc_f", pc_f, 32'h4180);
    chk("exc.im_addr", 32'(im_addr), 32'd1120);
    chk_ifid("exc", 32'd0, 32'h4180, 5'd0, 1'b0);

    // eret back to EPC
    exc_req = 1'b0; stall = 1'b0; eret = 1'b1; epc = 32'h3024;
    step();
    chk("eret.pc_f", pc_f, 32'h3024);
    chk("eret.im_addr", 32'(im_addr), 32'd9);
    chk_ifid("eret", 32'd0, 32'h3024, 5'd0, 1'b0);

    // Misaligned fetch
    eret = 1'b0; br_taken = 1'b1; br_target = 32'h3002;
    step();
    chk("mis.pc_f", pc_f, 32'h3002);
    chk("mis.im_exc", 32'(im_exc), 32'd1);
    chk_ifid("mis.pre", 32'hC0DE_0009, 32'h3024, 5'd0, 1'b0);
    br_taken = 1'b0;
    step();
    chk("mis.pc_adv", pc_f, 32'h3006);
    chk_ifid("mis", 32'd0, 32'h3002, 5'd4, 1'b0);

    // Out-of-range fetch
    br_taken = 1'b1; br_target = 32'h7000;
    step();
    chk("oor.pc_f", pc_f, 32'h7000);
    chk("oor.im_exc", 32'(im_exc), 32'd1);
    br_taken = 1'b0;
    step();
    chk_ifid("oor", 32'd0, 32'h7000, 5'd4, 1'b0);

    // Range boundaries: last legal word, and just below base
    br_taken = 1'b1; br_target = 32'h6FFC;
    step();
    chk("last.im_exc", 32'(im_exc), 32'd0);
    chk("last.im_addr", 32'(im_addr), 32'd4095);
    br_target = 32'h2FFC;
    step();
    chk_ifid("last", 32'hC0DE_0FFF, 32'h6FFC, 5'd0, 1'b0);
    chk("low.im_exc", 32'(im_exc), 32'd1);

    // exc_req and eret together: exception wins
    br_taken = 1'b0; exc_req = 1'b1; eret = 1'b1; epc = 32'h3024;
    step();
    chk("exc_eret.pc_f", pc_f, 32'h4180);
    chk_ifid("exc_eret", 32'd0, 32'h4180, 5'd0, 1'b0);

    exc_req = 1'b0; eret = 1'b0;
    step();
    chk("pre_rst.pc_f", pc_f, 32'h4184);
    chk_ifid("pre_rst", 32'hC0DE_0460, 32'h4180, 5'd0, 1'b0);

    // Reset coinciding with a branch redirect
    reset = 1'b1; br_taken = 1'b1; br_in_d = 1'b1; br_target = 32'h3100;
    step();
    chk("rst_br.pc_f", pc_f, 32'h3000);
    chk_ifid("rst_br", 32'd0, 32'd0, 5'd0, 1'b0);
    reset = 1'b0; br_taken = 1'b0; br_in_d = 1'b0;
    step();
    chk("post_rst.pc_f", pc_f, 32'h3004);
    chk_ifid("post_rst", 32'hC0DE_0000, 32'h3000, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
